rv32_memory: RTL

- Memory stage of the 5-stage RV32 pipeline. It sits directly downstream of the execute stage and consumes its E/M pipeline outputs.
- Performs data loads and stores over a valid/ready data-memory port, with byte-lane steering, sign/zero extension and misalignment/timeout exception generation.
- Requests a pipeline stall while an access is outstanding.
- Registers results into the M/W pipeline register for writeback.

---
 rtl/rv32_memory.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv32_memory.sv
// rv32_memory -- memory stage of the 5-stage RV32 pipeline.
//
// Issues loads and stores over a valid/ready data-memory port. It steers
// byte lanes, sign- or zero-extends load data, and raises misalignment and
// bus-timeout exceptions. While an access is outstanding it requests a
// pipeline stall. Results are registered into the M/W pipeline register.
//
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   reg_write_i .. write_data_i   E/M pipeline inputs (control, instr, PC+4,
//                             effective address, store data, exceptions)
//   dmem_*                    data-memory request/response port
//   stall_o                   freeze request to the hazard unit
//   reg_write_o .. read_data_o    M/W pipeline register outputs

`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 32
`endif

module rv32_memory #(
    parameter int unsigned EXC_LD_MISALIGN  = 4,
    parameter int unsigned EXC_ST_MISALIGN  = 6,
    parameter int unsigned EXC_ACCESS_FAULT = 5,
    parameter int unsigned TIMEOUT_CYCLES   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        reg_write_i,
    input  logic                        memory_write_i,
    input  logic [2:0]                  result_source_i,
    input  logic [`EXCEPTION_WIDTH-1:0] exceptions_i,
    input  logic [31:0]                 instr_i,
    input  logic [31:0]                 pc_next_i,
    input  logic [31:0]                 alu_result_i,
    input  logic [31:0]                 write_data_i,
    output logic                        dmem_valid_o,
    input  logic                        dmem_ready_i,
    output logic                        dmem_we_o,
    output logic [31:0]                 dmem_addr_o,
    output logic [3:0]                  dmem_be_o,
    output logic [31:0]                 dmem_wdata_o,
    input  logic [31:0]                 dmem_rdata_i,
    output logic                        stall_o,
    output logic                        reg_write_o,
    output logic [2:0]                  result_source_o,
    output logic [`EXCEPTION_WIDTH-1:0] exceptions_o,
    output logic [31:0]                 instr_o,
    output logic [31:0]                 pc_next_o,
    output logic [31:0]                 alu_result_o,
    output logic [31:0]                 read_data_o
);

    localparam int unsigned   EW           = `EXCEPTION_WIDTH;
    localparam int unsigned   CW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] count, count_next;

    logic [2:0]    funct3;
    logic [1:0]    size;
    logic [1:0]    addr_lo;
    logic          is_load;
    logic          mem_req;
    logic          no_exc;
    logic          aligned;
    logic          access;
    logic          misalign;
    logic [3:0]    be_raw;
    logic [31:0]   lane;
    logic [31:0]   load_data;
    logic          req_valid;
    logic          req_stall;
    logic          timeout;
    logic [EW-1:0] exc_add;

    assign funct3  = instr_i[14:12];
    assign size    = funct3[1:0];
    assign addr_lo = alu_result_i[1:0];
    assign is_load = (result_source_i == 3'b001);
    assign mem_req = memory_write_i | is_load;
    assign no_exc  = (exceptions_i == '0);

    always_comb begin
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign access   = mem_req & no_exc & aligned;
    assign misalign = mem_req & no_exc & ~aligned;

    // Byte lanes and replicated store data
    always_comb begin
        case (size)
            2'b00: begin
                be_raw       = 4'b0001 << addr_lo;
                dmem_wdata_o = {4{write_data_i[7:0]}};
            end
            2'b01: begin
                be_raw       = 4'b0011 << addr_lo;
                dmem_wdata_o = {2{write_data_i[15:0]}};
            end
            2'b10: begin
                be_raw       = 4'b1111;
                dmem_wdata_o = write_data_i;
            end
            default: begin
                be_raw       = '0;
                dmem_wdata_o = write_data_i;
            end
        endcase
    end

    assign dmem_addr_o = {alu_result_i[31:2], 2'b00};

    // Load extract: move the addressed lane down to bit 0, then extend
    assign lane = dmem_rdata_i >> {addr_lo, 3'b000};

    always_comb begin
        case (size)
            2'b00:   load_data = funct3[2] ? {24'h0, lane[7:0]}
                                           : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = funct3[2] ? {16'h0, lane[15:0]}
                                           : {{16{lane[15]}}, lane[15:0]};
            default: load_data = dmem_rdata_i;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // FSM next state and request/stall outputs
    always_comb begin
        state_next = state;
        count_next = count;
        req_valid  = 1'b0;
        req_stall  = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    req_valid = 1'b1;
                    if (!dmem_ready_i) begin
                        req_stall  = 1'b1;
                        state_next = S_WAIT;
                        count_next = CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (count == TIMEOUT_LAST) begin
                    // Abandon: valid drops, the pipeline is released and
                    // the fault is recorded in M/W this cycle.
                    timeout    = 1'b1;
                    state_next = S_IDLE;
                    count_next = '0;
                end else begin
                    req_valid = 1'b1;
                    if (dmem_ready_i) begin
                        state_next = S_IDLE;
                        count_next = '0;
                    end else begin
                        req_stall  = 1'b1;
                        count_next = count + CW'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    // While reset is held no access is presented, whatever the inputs show
    assign dmem_valid_o = req_valid & rst_n_i;
    assign stall_o      = req_stall & rst_n_i;
    assign dmem_we_o    = dmem_valid_o & memory_write_i;
    assign dmem_be_o    = dmem_valid_o ? be_raw : 4'b0000;

    always_comb begin
        exc_add = '0;
        if (misalign) begin
            if (memory_write_i) exc_add[EXC_ST_MISALIGN] = 1'b1;
            else                exc_add[EXC_LD_MISALIGN] = 1'b1;
        end
        if (timeout) exc_add[EXC_ACCESS_FAULT] = 1'b1;
    end

    // M/W pipeline register; a stall inserts a bubble
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_write_o     <= 1'b0;
            result_source_o <= '0;
            exceptions_o    <= '0;
            instr_o         <= '0;
            pc_next_o       <= '0;
            alu_result_o    <= '0;
            read_data_o     <= '0;
        end else if (!stall_o) begin
            reg_write_o     <= reg_write_i & ~memory_write_i & ~misalign & ~timeout;
            result_source_o <= result_source_i;
            exceptions_o    <= exceptions_i | exc_add;
            instr_o         <= instr_i;
            pc_next_o       <= pc_next_i;
            alu_result_o    <= alu_result_i;
            read_data_o     <= load_data;
        end else begin
            reg_write_o     <= 1'b0;
            result_source_o <= '0;
            exceptions_o    <= '0;
        end
    end

endmodule
